// File: rtl/pair_judge.sv
// rtl/pair_judge.sv - pair confirm judge: colour lookup, match/miss scoring, step advance
// Optional miss limit: define PAIR_JUDGE_MISS_LIMIT_EN to end the game after MAX_MISS mismatches.
module pair_judge #(
    parameter int MAX_MISS = 3
) (
    input  logic        clk25MHz,
    input  logic        rst,
    input  logic        confirm,
    input  logic [3:0]  step_in,
    input  logic [2:0]  secim,
    input  logic [2:0]  es,
    input  logic [23:0] color_map,
    output logic        judge_valid,
    output logic        match,
    output logic        step_adv,
    output logic        reject,
    output logic [7:0]  matched_mask,
    output logic [2:0]  score,
    output logic [2:0]  miss_count,
    output logic        game_over
);

    typedef enum logic [2:0] {IDLE, LOOKUP, COMPARE, REPORT, WAIT_REL} state_t;

    localparam logic [2:0] LP_MISS_LIMIT = 3'(MAX_MISS);

    state_t     r_state;
    logic       r_confirm_q;
    logic [2:0] r_sel_a;
    logic [2:0] r_sel_b;
    logic [2:0] r_col_a;
    logic [2:0] r_col_b;
    logic       r_judge_valid;
    logic       r_match;
    logic       r_step_adv;
    logic       r_reject;
    logic [7:0] r_mask;
    logic [2:0] r_score;
    logic       r_game_over;
`ifdef PAIR_JUDGE_MISS_LIMIT_EN
    logic [2:0] r_miss;
`endif

    logic [2:0] w_color [8];
    logic       w_cfm_edge;
    logic       w_pair_step;
    logic       w_illegal;
    logic       w_miss_hit;

    genvar g;
    generate
        for (g = 0; g < 8; g++) begin : g_color
            assign w_color[g] = color_map[3*g +: 3];
        end
    endgenerate

    assign w_cfm_edge  = confirm & ~r_confirm_q;
    assign w_pair_step = (step_in == 4'b0011) || (step_in == 4'b0101) ||
                         (step_in == 4'b0111) || (step_in == 4'b1001);
    assign w_illegal   = (secim == es) || r_mask[secim] || r_mask[es];
    // With the limit disabled miss_count stays 0, which never equals a legal MAX_MISS (1..7).
    assign w_miss_hit  = (miss_count == LP_MISS_LIMIT);

    always_ff @(posedge clk25MHz) begin
        if (rst) begin
            r_state       <= IDLE;
            r_confirm_q   <= 1'b0;
            r_sel_a       <= 3'd0;
            r_sel_b       <= 3'd0;
            r_col_a       <= 3'd0;
            r_col_b       <= 3'd0;
            r_judge_valid <= 1'b0;
            r_match       <= 1'b0;
            r_step_adv    <= 1'b0;
            r_reject      <= 1'b0;
            r_mask        <= 8'h00;
            r_score       <= 3'd0;
            r_game_over   <= 1'b0;
`ifdef PAIR_JUDGE_MISS_LIMIT_EN
            r_miss        <= 3'd0;
`endif
        end else begin
            r_confirm_q   <= confirm;
            r_judge_valid <= 1'b0;
            r_step_adv    <= 1'b0;
            r_reject      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_cfm_edge && w_pair_step && !r_game_over) begin
                        if (w_illegal) begin
                            r_reject <= 1'b1;
                            r_state  <= WAIT_REL;
                        end else begin
                            r_sel_a <= secim;
                            r_sel_b <= es;
                            r_state <= LOOKUP;
                        end
                    end
                end
                LOOKUP: begin
                    // Colours are frozen here so later color_map edits cannot alter the verdict.
                    r_col_a <= w_color[r_sel_a];
                    r_col_b <= w_color[r_sel_b];
                    r_state <= COMPARE;
                end
                COMPARE: begin
                    r_judge_valid <= 1'b1;
                    r_step_adv    <= 1'b1;
                    r_match       <= (r_col_a == r_col_b);
                    if (r_col_a == r_col_b) begin
                        r_mask <= r_mask | (8'b1 << r_sel_a) | (8'b1 << r_sel_b);
                        if (r_score != 3'd4)
                            r_score <= r_score + 3'd1;
                    end
`ifdef PAIR_JUDGE_MISS_LIMIT_EN
                    else if (r_miss != 3'd7) begin
                        r_miss <= r_miss + 3'd1;
                    end
`endif
                    r_state <= REPORT;
                end
                REPORT: begin
                    r_game_over <= r_game_over || (r_score == 3'd4) || w_miss_hit;
                    r_state     <= WAIT_REL;
                end
                WAIT_REL: begin
                    if (!confirm)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign judge_valid  = r_judge_valid;
    assign match        = r_match;
    assign step_adv     = r_step_adv;
    assign reject       = r_reject;
    assign matched_mask = r_mask;
    assign score        = r_score;
    assign game_over    = r_game_over;
`ifdef PAIR_JUDGE_MISS_LIMIT_EN
    assign miss_count   = r_miss;
`else
    assign miss_count   = 3'd0;
`endif

endmodule

// File: tb/tb_pair_judge.sv
// tb/tb_pair_judge.sv - randomized self-checking bench for pair_judge against a rule-level model
module tb_pair_judge;

    localparam int MAXM = 3;

    logic        clk25MHz = 1'b0;
    logic        rst = 1'b1;
    logic        confirm = 1'b0;
    logic [3:0]  step_in = 4'd0;
    logic [2:0]  secim = 3'd0;
    logic [2:0]  es = 3'd0;
    logic [23:0] color_map = 24'd0;
    logic        judge_valid, match, step_adv, reject, game_over;
    logic [7:0]  matched_mask;
    logic [2:0]  score, miss_count;

    pair_judge #(.MAX_MISS(MAXM)) dut (
        .clk25MHz(clk25MHz), .rst(rst), .confirm(confirm), .step_in(step_in),
        .secim(secim), .es(es), .color_map(color_map), .judge_valid(judge_valid),
        .match(match), .step_adv(step_adv), .reject(reject),
        .matched_mask(matched_mask), .score(score), .miss_count(miss_count),
        .game_over(game_over)
    );

    always #20 clk25MHz = ~clk25MHz;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] m_mask;
    int         m_score, m_miss;
    logic       m_go, m_match;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit is_pair(input logic [3:0] s);
        return (s == 4'd3) || (s == 4'd5) || (s == 4'd7) || (s == 4'd9);
    endfunction

    function automatic logic [2:0] colour_of(input logic [23:0] cm, input logic [2:0] sq);
        logic [23:0] t;
        t = cm >> (3 * int'(sq));
        return t[2:0];
    endfunction

    task automatic model_clear();
        m_mask = 8'h00; m_score = 0; m_miss = 0; m_go = 1'b0; m_match = 1'b0;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".match"}, 32'(match), 32'(m_match));
        chk({tag, ".mask"}, 32'(matched_mask), 32'(m_mask));
        chk({tag, ".score"}, 32'(score), 32'(m_score));
        chk({tag, ".miss"}, 32'(miss_count), 32'(m_miss));
        chk({tag, ".game_over"}, 32'(game_over), 32'(m_go));
    endtask

    task automatic do_reset();
        @(negedge clk25MHz);
        rst = 1'b1;
        confirm = 1'b1;
        @(negedge clk25MHz);
        confirm = 1'b0;
        @(negedge clk25MHz);
        rst = 1'b0;
        model_clear();
        chk("rst.pulses", {29'd0, judge_valid, step_adv, reject}, 32'd0);
        chk_state("rst");
    endtask

    // Applies one confirm press held for 'hold' cycles and checks the response against the model.
    task automatic run_txn(input string tag, input logic [3:0] st, input logic [2:0] a,
                           input logic [2:0] b, input logic [23:0] cm, input int hold);
        int cls, jv_n, jv_at, rj_n, rj_at, sa_diff;
        logic exp_eq;
        cls = 0;
        if (is_pair(st) && !m_go)
            cls = ((a == b) || m_mask[a] || m_mask[b]) ? 1 : 2;
        exp_eq = (colour_of(cm, a) == colour_of(cm, b));
        if (cls == 2) begin
            m_match = exp_eq;
            if (exp_eq) begin
                m_mask = m_mask | (8'b1 << a) | (8'b1 << b);
                if (m_score < 4) m_score++;
            end else begin
`ifdef PAIR_JUDGE_MISS_LIMIT_EN
                if (m_miss < 7) m_miss++;
`endif
            end
            if (m_score == 4) m_go = 1'b1;
`ifdef PAIR_JUDGE_MISS_LIMIT_EN
            if (m_miss == MAXM) m_go = 1'b1;
`endif
        end
        jv_n = 0; jv_at = 0; rj_n = 0; rj_at = 0; sa_diff = 0;
        @(negedge clk25MHz);
        step_in = st; secim = a; es = b; color_map = cm; confirm = 1'b1;
        for (int k = 1; k <= hold + 3; k++) begin
            @(negedge clk25MHz);
            if (judge_valid) begin jv_n++; jv_at = k; end
            if (reject) begin rj_n++; rj_at = k; end
            if (step_adv !== judge_valid) sa_diff++;
            if (k == 1) begin
                step_in = 4'($urandom);
                secim = 3'($urandom);
                es = 3'($urandom);
            end
            if (k == 2) color_map = 24'($urandom);
            if (k == 3 && cls == 2) begin
                chk({tag, ".match@pulse"}, 32'(match), 32'(m_match));
                chk({tag, ".score@pulse"}, 32'(score), 32'(m_score));
            end
            if (k == 4) chk({tag, ".game_over@N+3"}, 32'(game_over), 32'(m_go));
            if (k == hold) confirm = 1'b0;
        end
        chk({tag, ".jv_count"}, 32'(jv_n), (cls == 2) ? 32'd1 : 32'd0);
        if (cls == 2) chk({tag, ".jv_latency"}, 32'(jv_at), 32'd3);
        chk({tag, ".reject_count"}, 32'(rj_n), (cls == 1) ? 32'd1 : 32'd0);
        if (cls == 1) chk({tag, ".reject_latency"}, 32'(rj_at), 32'd1);
        chk({tag, ".step_adv_vs_jv"}, 32'(sa_diff), 32'd0);
        chk_state(tag);
    endtask

    task automatic reset_mid_verdict();
        int jv_n;
        jv_n = 0;
        @(negedge clk25MHz);
        step_in = 4'd3; secim = 3'd0; es = 3'd5; color_map = 24'h0; confirm = 1'b1;
        @(negedge clk25MHz);
        @(negedge clk25MHz);
        rst = 1'b1;
        @(negedge clk25MHz);
        rst = 1'b0;
        confirm = 1'b0;
        model_clear();
        chk("rstmid.pulses", {29'd0, judge_valid, step_adv, reject}, 32'd0);
        chk_state("rstmid");
        for (int k = 0; k < 6; k++) begin
            @(negedge clk25MHz);
            if (judge_valid) jv_n++;
        end
        chk("rstmid.no_jv", 32'(jv_n), 32'd0);
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] cm;
        logic [3:0]  st;
        logic [2:0]  a, b;
        logic [3:0]  pair_steps [4];
        pair_steps[0] = 4'd3; pair_steps[1] = 4'd5; pair_steps[2] = 4'd7; pair_steps[3] = 4'd9;

        do_reset();
        // sq7..sq0 = 7,6,4,5,3,1,2,4
        cm = {3'd7, 3'd6, 3'd4, 3'd5, 3'd3, 3'd1, 3'd2, 3'd4};
        run_txn("match05", 4'b0011, 3'd0, 3'd5, cm, 4);
        run_txn("miss12", 4'b0101, 3'd1, 3'd2, cm, 4);
        run_txn("same33", 4'b0111, 3'd3, 3'd3, cm, 4);
        run_txn("reuse0", 4'b0111, 3'd0, 3'd4, cm, 5);
        run_txn("offstep", 4'b0110, 3'd1, 3'd3, cm, 50);
        run_txn("hold50", 4'b0111, 3'd1, 3'd3, cm, 50);
        run_txn("miss24", 4'b1001, 3'd2, 3'd4, cm, 4);
        run_txn("after3", 4'b1001, 3'd6, 3'd7, cm, 4);

        do_reset();
        reset_mid_verdict();
        run_txn("postrst", 4'b0011, 3'd0, 3'd5, cm, 4);

        for (int ep = 0; ep < 6; ep++) begin
            do_reset();
            cm = 24'($urandom);
            for (int t = 0; t < 14; t++) begin
                if ($urandom_range(0, 4) == 0) st = 4'($urandom);
                else st = pair_steps[$urandom_range(0, 3)];
                a = 3'($urandom);
                b = 3'($urandom);
                if ($urandom_range(0, 2) == 0)
                    cm = (cm & ~(24'h7 << (3 * int'(b)))) | (24'(colour_of(cm, a)) << (3 * int'(b)));
                run_txn("rand", st, a, b, cm, $urandom_range(4, 7));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pair_judge.md
# pair_judge

Downstream stage of the pair-selection steps in the 8-square colour matching game. When the player confirms a pair (first pick `secim`, partner pick `es`) during a pair step, the block looks up both squares' colours, judges match/mismatch, and updates the matched-square mask and score. It also tracks misses and pulses a step-advance request to the step sequencer. Its outputs drive the VGA renderer (revealed/matched squares) and the end-of-game logic.

## Interface
- `MAX_MISS`, default 3: number of mismatches that ends the game (1..7).
- `clk25MHz`  in  1  system/pixel clock; every register is clocked on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `confirm`  in  1  confirm button, level; rising edge detected internally.
- `step_in`  in  4  current game step from the sequencer.
- `secim`  in  3  first square of the current pair.
- `es`  in  3  partner square of the current pair.
- `color_map`  in  24  colour of square k at bits [3k+2:3k].
- `judge_valid`  out  1  one-cycle pulse: verdict available.
- `match`  out  1  last verdict (1 = colours equal); held until next verdict.
- `step_adv`  out  1  one-cycle pulse coincident with `judge_valid`; requests the next step.
- `reject`  out  1  one-cycle pulse: confirm refused (illegal pair).
- `matched_mask`  out  8  bit k set once square k is part of a matched pair.
- `score`  out  3  matched pairs, 0..4.
- `miss_count`  out  3  mismatches so far.
- `game_over`  out  1  sticky end-of-game flag.

## Operation
- Pair steps are exactly `step_in` ∈ {4'b0011, 4'b0101, 4'b0111, 4'b1001} (pairs 1..4). Confirms outside these steps are ignored, with no `reject`.
- Edge detect: `confirm_q` registers `confirm`; `cfm_edge = confirm & ~confirm_q`.
- FSM states: IDLE, LOOKUP, COMPARE, REPORT, WAIT_REL.
  - IDLE: on `cfm_edge`, in a pair step, with `game_over`=0:
    - if `secim`==`es`, or either square is already set in `matched_mask`: pulse `reject` and go to WAIT_REL.
    - else: latch `secim`, `es`, and `step_in`, then go to LOOKUP.
  - LOOKUP: register colour A = `color_map[3*secim +: 3]` and colour B = `color_map[3*es +: 3]`; go to COMPARE.
  - COMPARE: `match` <= (A==B).
    - Match: set both bits in `matched_mask` and increment `score`.
    - Mismatch: increment `miss_count`.
    - Go to REPORT.
  - REPORT: pulse `judge_valid` and `step_adv`; evaluate `game_over`; go to WAIT_REL.
  - WAIT_REL: stay until `confirm`==0, then go to IDLE. Holding the button never re-triggers.
- `game_over` is set when `score`==4, or (macro enabled) when `miss_count`==`MAX_MISS`. Once set, it stays set until `rst`; all confirms are then ignored.
- `score` saturates at 4 and `miss_count` saturates at 7; neither wraps.
- `color_map` changes after LOOKUP have no effect on the pending verdict.

## Timing
- Reset values (all outputs and state): `judge_valid`=0, `match`=0, `step_adv`=0, `reject`=0, `matched_mask`=8'h00, `score`=0, `miss_count`=0, `game_over`=0, FSM=IDLE, `confirm_q`=0.
- `confirm` first sampled high at edge N (IDLE): LOOKUP at N, COMPARE at N+1, REPORT at N+2.
  - `judge_valid`/`step_adv` are high for exactly the cycle between edges N+2 and N+3.
  - `match`/`score`/`matched_mask`/`miss_count` are updated at edge N+2, visible together with the pulse.
  - `game_over` is updated at edge N+3.
- `reject` is high for the one cycle after edge N.
- `rst` has priority over everything, including a simultaneous confirm. A reset mid-verdict (LOOKUP/COMPARE/REPORT) abandons it: no pulse, counters cleared.
- `step_in` changing after latch does not abort a verdict in progress.

## Configuration
- `PAIR_JUDGE_MISS_LIMIT_EN`:
  - defined: `miss_count` counts and `game_over` also asserts at `MAX_MISS` misses.
  - undefined: `miss_count` is tied to 0 and the game ends only at `score`==4.

## Test plan
- `color_map` sq0=3'b100, sq5=3'b100; step 4'b0011, `secim`=0, `es`=5, confirm pulse → `judge_valid` 2 cycles after the sampling edge, `match`=1, `matched_mask`=8'b0010_0001, `score`=1, one `step_adv`.
- sq1=3'b010, sq2=3'b001; step 4'b0101, pair (1,2) → `match`=0, `miss_count`=1, mask unchanged.
- `secim`=`es`=3, or square 0 reused after it was matched → `reject` pulse, no `judge_valid`, counters unchanged.
- Hold `confirm` high for 50 cycles → exactly one `judge_valid`; confirm at step 4'b0110 → no response.
- Macro defined, `MAX_MISS`=3, three mismatching pairs → `game_over`=1 one cycle after the third `judge_valid`; a fourth confirm is ignored. Macro undefined: `game_over` stays 0.
- Assert `rst` during COMPARE → next cycle all outputs are 0 and the FSM is IDLE; no `judge_valid` is produced.
